// File: rtl/route_lookup_pkg.sv
// +----------------------------------------------------------------------+
// | route_lookup_pkg                                                     |
// | Shared widths, flag positions and slot-entry type for the lookup     |
// | client.                                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package route_lookup_pkg;

    localparam int FLAG_DIRECT  = 0;
    localparam int FLAG_BCAST   = 1;
    localparam int FLAG_DEFAULT = 2;
    localparam int FLAG_W       = 3;

    localparam int PORT_W = 16;
    localparam int QP_W   = 16;
    localparam int MAC_W  = 48;
    localparam int IP_W   = 32;

    localparam int LOOKUP_LATENCY_DEFAULT = 3;

    // Response half of a slot; the tag lives beside it because its width is a module parameter.
    typedef struct packed {
        logic              found;
        logic [PORT_W-1:0] out_port;
        logic [QP_W-1:0]   out_qp;
        logic [MAC_W-1:0]  next_hop_mac;
        logic [FLAG_W-1:0] flags;
    } rl_slot_t;

endpackage

`default_nettype wire

// File: rtl/rl_slot_buf.sv
// +----------------------------------------------------------------------+
// | rl_slot_buf                                                          |
// | DEPTH-entry slot array: tag write port, response write port and an   |
// | asynchronous read port.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rl_slot_buf
    import route_lookup_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_tag_we,
    input  logic [AW-1:0]    i_tag_addr,
    input  logic [TAG_W-1:0] i_tag_wdata,
    input  logic             i_rsp_we,
    input  logic [AW-1:0]    i_rsp_addr,
    input  rl_slot_t         i_rsp_wdata,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [TAG_W-1:0] o_rd_tag,
    output rl_slot_t         o_rd_rsp
);

    logic [TAG_W-1:0] r_tag [DEPTH];
    rl_slot_t         r_rsp [DEPTH];

    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_tag_addr] <= i_tag_wdata;
        end
        if (i_rsp_we) begin
            r_rsp[i_rsp_addr] <= i_rsp_wdata;
        end
    end

    assign o_rd_tag = r_tag[i_rd_addr];
    assign o_rd_rsp = r_rsp[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/route_lookup_client.sv
// +----------------------------------------------------------------------+
// | route_lookup_client                                                  |
// | Issues router lookups for packet descriptors and returns in-order    |
// | tagged forwarding decisions; storage is reserved before each issue.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module route_lookup_client
    import route_lookup_pkg::*;
#(
    parameter int TAG_W          = 16,
    parameter int DEPTH          = 8,
    parameter int LOOKUP_LATENCY = LOOKUP_LATENCY_DEFAULT,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              router_init_done,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [IP_W-1:0]   pkt_dst_ip,
    input  logic [TAG_W-1:0]  pkt_tag,
    output logic              lookup_valid,
    output logic [IP_W-1:0]   lookup_dst_ip,
    input  logic              resp_valid,
    input  logic              resp_found,
    input  logic [PORT_W-1:0] resp_out_port,
    input  logic [QP_W-1:0]   resp_out_qp,
    input  logic [MAC_W-1:0]  resp_next_hop_mac,
    input  logic              resp_is_direct_host,
    input  logic              resp_is_broadcast,
    input  logic              resp_is_default_route,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    output logic [TAG_W-1:0]  fwd_tag,
    output logic              fwd_found,
    output logic [PORT_W-1:0] fwd_out_port,
    output logic [QP_W-1:0]   fwd_out_qp,
    output logic [MAC_W-1:0]  fwd_next_hop_mac,
    output logic [FLAG_W-1:0] fwd_flags,
    output logic [CNT_W-1:0]  cnt_issued,
    output logic [CNT_W-1:0]  cnt_miss,
    output logic              err_unexpected_resp
);

    localparam int c_aw           = $clog2(DEPTH);
    localparam int c_pw           = c_aw + 1;
    localparam int c_quiet_cycles = LOOKUP_LATENCY + 2;
    localparam int c_qw           = $clog2(c_quiet_cycles + 1);

    localparam logic [c_pw-1:0]  c_ptr_one    = c_pw'(1);
    localparam logic [c_pw-1:0]  c_depth      = c_pw'(DEPTH);
    localparam logic [c_qw-1:0]  c_quiet_one  = c_qw'(1);
    localparam logic [c_qw-1:0]  c_quiet_last = c_qw'(c_quiet_cycles);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    logic [c_pw-1:0]  r_iss_ptr;
    logic [c_pw-1:0]  r_rsp_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic             r_quiet;
    logic [c_qw-1:0]  r_quiet_cnt;
    logic             r_lookup_valid;
    logic [IP_W-1:0]  r_lookup_dst_ip;
    logic [CNT_W-1:0] r_cnt_issued;
    logic [CNT_W-1:0] r_cnt_miss;
    logic             r_err;

    logic [c_pw-1:0]  w_reserved;
    logic             w_pkt_ready;
    logic             w_accept;
    logic             w_rsp_take;
    logic             w_rsp_spurious;
    logic             w_fwd_valid;
    logic             w_pop;
    rl_slot_t         w_rsp_word;
    rl_slot_t         w_rd_rsp;
    rl_slot_t         w_fwd;
    logic [TAG_W-1:0] w_rd_tag;

    // Slots count as reserved from issue until popped, so a response always has a home.
    assign w_reserved     = r_iss_ptr - r_rd_ptr;
    assign w_pkt_ready    = rst_n & router_init_done & ~r_quiet & (w_reserved < c_depth);
    assign w_accept       = pkt_valid & w_pkt_ready;
    assign w_rsp_take     = resp_valid & (r_rsp_ptr != r_iss_ptr);
    assign w_rsp_spurious = resp_valid & (r_rsp_ptr == r_iss_ptr) & ~r_quiet;
    assign w_fwd_valid    = (r_rd_ptr != r_rsp_ptr);
    assign w_pop          = w_fwd_valid & fwd_ready;

    always_comb begin
        w_rsp_word                      = '0;
        w_rsp_word.found                = resp_found;
        w_rsp_word.out_port             = resp_out_port;
        w_rsp_word.out_qp               = resp_out_qp;
        w_rsp_word.next_hop_mac         = resp_next_hop_mac;
        w_rsp_word.flags[FLAG_DIRECT]   = resp_is_direct_host;
        w_rsp_word.flags[FLAG_BCAST]    = resp_is_broadcast;
        w_rsp_word.flags[FLAG_DEFAULT]  = resp_is_default_route;
    end

    rl_slot_buf #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .AW    (c_aw)
    ) u_slot_buf (
        .clk         (clk),
        .i_tag_we    (w_accept),
        .i_tag_addr  (r_iss_ptr[c_aw-1:0]),
        .i_tag_wdata (pkt_tag),
        .i_rsp_we    (w_rsp_take),
        .i_rsp_addr  (r_rsp_ptr[c_aw-1:0]),
        .i_rsp_wdata (w_rsp_word),
        .i_rd_addr   (r_rd_ptr[c_aw-1:0]),
        .o_rd_tag    (w_rd_tag),
        .o_rd_rsp    (w_rd_rsp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iss_ptr       <= '0;
            r_rsp_ptr       <= '0;
            r_rd_ptr        <= '0;
            r_quiet         <= 1'b1;
            r_quiet_cnt     <= '0;
            r_lookup_valid  <= 1'b0;
            r_lookup_dst_ip <= '0;
            r_cnt_issued    <= '0;
            r_cnt_miss      <= '0;
            r_err           <= 1'b0;
        end else begin
            // Quiet window swallows responses to lookups abandoned by the reset.
            if (r_quiet) begin
                if (r_quiet_cnt == c_quiet_last) begin
                    r_quiet <= 1'b0;
                end else begin
                    r_quiet_cnt <= r_quiet_cnt + c_quiet_one;
                end
            end

            r_lookup_valid <= w_accept;
            if (w_accept) begin
                r_iss_ptr       <= r_iss_ptr + c_ptr_one;
                r_lookup_dst_ip <= pkt_dst_ip;
                r_cnt_issued    <= r_cnt_issued + c_cnt_one;
            end

            if (w_rsp_take) begin
                r_rsp_ptr <= r_rsp_ptr + c_ptr_one;
                if (!resp_found) begin
                    r_cnt_miss <= r_cnt_miss + c_cnt_one;
                end
            end

            if (w_rsp_spurious) begin
                r_err <= 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Empty slots read as zero so stale contents never show on the output.
    assign w_fwd = w_fwd_valid ? w_rd_rsp : '0;

    assign pkt_ready           = w_pkt_ready;
    assign lookup_valid        = r_lookup_valid;
    assign lookup_dst_ip       = r_lookup_dst_ip;
    assign fwd_valid           = w_fwd_valid;
    assign fwd_tag             = w_fwd_valid ? w_rd_tag : '0;
    assign fwd_found           = w_fwd.found;
    assign fwd_out_port        = w_fwd.out_port;
    assign fwd_out_qp          = w_fwd.out_qp;
    assign fwd_next_hop_mac    = w_fwd.next_hop_mac;
    assign fwd_flags           = w_fwd.flags;
    assign cnt_issued          = r_cnt_issued;
    assign cnt_miss            = r_cnt_miss;
    assign err_unexpected_resp = r_err;

endmodule

`default_nettype wire

// File: tb/tb_route_lookup_client.sv
// +----------------------------------------------------------------------+
// | tb_route_lookup_client                                               |
// | Directed bench with a fixed-latency stub router and a vector table.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_route_lookup_client;
    import route_lookup_pkg::*;

    localparam int TAG_W = 16;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              router_init_done;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [31:0]       pkt_dst_ip;
    logic [TAG_W-1:0]  pkt_tag;
    logic              lookup_valid;
    logic [31:0]       lookup_dst_ip;
    logic              resp_valid;
    logic              resp_found;
    logic [15:0]       resp_out_port;
    logic [15:0]       resp_out_qp;
    logic [47:0]       resp_next_hop_mac;
    logic              resp_is_direct_host;
    logic              resp_is_broadcast;
    logic              resp_is_default_route;
    logic              fwd_valid;
    logic              fwd_ready;
    logic [TAG_W-1:0]  fwd_tag;
    logic              fwd_found;
    logic [15:0]       fwd_out_port;
    logic [15:0]       fwd_out_qp;
    logic [47:0]       fwd_next_hop_mac;
    logic [2:0]        fwd_flags;
    logic [CNT_W-1:0]  cnt_issued;
    logic [CNT_W-1:0]  cnt_miss;
    logic              err_unexpected_resp;

    route_lookup_client #(
        .TAG_W          (TAG_W),
        .DEPTH          (DEPTH),
        .LOOKUP_LATENCY (LAT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .router_init_done      (router_init_done),
        .pkt_valid             (pkt_valid),
        .pkt_ready             (pkt_ready),
        .pkt_dst_ip            (pkt_dst_ip),
        .pkt_tag               (pkt_tag),
        .lookup_valid          (lookup_valid),
        .lookup_dst_ip         (lookup_dst_ip),
        .resp_valid            (resp_valid),
        .resp_found            (resp_found),
        .resp_out_port         (resp_out_port),
        .resp_out_qp           (resp_out_qp),
        .resp_next_hop_mac     (resp_next_hop_mac),
        .resp_is_direct_host   (resp_is_direct_host),
        .resp_is_broadcast     (resp_is_broadcast),
        .resp_is_default_route (resp_is_default_route),
        .fwd_valid             (fwd_valid),
        .fwd_ready             (fwd_ready),
        .fwd_tag               (fwd_tag),
        .fwd_found             (fwd_found),
        .fwd_out_port          (fwd_out_port),
        .fwd_out_qp            (fwd_out_qp),
        .fwd_next_hop_mac      (fwd_next_hop_mac),
        .fwd_flags             (fwd_flags),
        .cnt_issued            (cnt_issued),
        .cnt_miss              (cnt_miss),
        .err_unexpected_resp   (err_unexpected_resp)
    );

    // ---------------- stub router: fixed latency, no reset ----------------
    typedef struct packed {
        logic        found;
        logic [15:0] port;
        logic [15:0] qp;
        logic [47:0] mac;
        logic        direct;
        logic        bcast;
        logic        dflt;
    } stub_rsp_t;

    function automatic stub_rsp_t stub_lookup(input logic [31:0] ip);
        stub_rsp_t r;
        r = '0;
        case (ip)
            32'h0a32b7fa: begin r.found = 1'b1; r.port = 16'h0003; r.qp = 16'h0011; r.mac = 48'h0011_2233_4455; r.direct = 1'b1; end
            32'h0a32b708: begin r.found = 1'b1; r.port = 16'h0005; r.qp = 16'h0022; r.mac = 48'hffff_ffff_ffff; r.bcast  = 1'b1; end
            32'h0a32b77d: begin r.found = 1'b1; r.port = 16'h0001; r.qp = 16'h0033; r.mac = 48'h00aa_bbcc_ddee; r.dflt   = 1'b1; end
            32'h0a32b7dd: begin r.found = 1'b1; r.port = 16'h0007; r.qp = 16'h0044; r.mac = 48'h0200_dead_beef; end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [LAT-1:0] stub_v = '0;
    logic [31:0]    stub_ip [LAT];
    logic           inj_valid;
    stub_rsp_t      sr;

    always @(posedge clk) begin
        stub_v     <= {stub_v[LAT-2:0], lookup_valid};
        stub_ip[0] <= lookup_dst_ip;
        for (int i = 1; i < LAT; i++) stub_ip[i] <= stub_ip[i-1];
    end

    always_comb sr = stub_lookup(stub_ip[LAT-1]);

    assign resp_valid            = stub_v[LAT-1] | inj_valid;
    assign resp_found            = stub_v[LAT-1] & sr.found;
    assign resp_out_port         = stub_v[LAT-1] ? sr.port : 16'h0;
    assign resp_out_qp           = stub_v[LAT-1] ? sr.qp   : 16'h0;
    assign resp_next_hop_mac     = stub_v[LAT-1] ? sr.mac  : 48'h0;
    assign resp_is_direct_host   = stub_v[LAT-1] & sr.direct;
    assign resp_is_broadcast     = stub_v[LAT-1] & sr.bcast;
    assign resp_is_default_route = stub_v[LAT-1] & sr.dflt;

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] ip;
        logic        found;
        logic [15:0] port;
        logic [15:0] qp;
        logic [47:0] mac;
        logic [2:0]  flags;
    } vec_t;
    vec_t vecs [5];

    typedef struct packed {
        logic [15:0] tag;
        logic        found;
        logic [15:0] port;
        logic [15:0] qp;
        logic [47:0] mac;
        logic [2:0]  flags;
    } exp_t;
    exp_t exp_q [$];
    int   pop_cyc [$];

    function automatic exp_t mk_exp(input logic [15:0] tag, input int vi);
        exp_t e;
        e.tag   = tag;
        e.found = vecs[vi].found;
        e.port  = vecs[vi].port;
        e.qp    = vecs[vi].qp;
        e.mac   = vecs[vi].mac;
        e.flags = vecs[vi].flags;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && fwd_valid && fwd_ready) begin
                act = {fwd_tag, fwd_found, fwd_out_port, fwd_out_qp, fwd_next_hop_mac, fwd_flags};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL fwd_unexpected: got tag %0h with no decision expected", fwd_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_errors++;
                        $display("FAIL fwd_decision: got %0h expected %0h", act, e);
                    end
                    pop_cyc.push_back(cyc);
                end
            end
        end
    endtask

    // Presents one descriptor until accepted; returns #1 after the accepting edge.
    task automatic send(input int vi, input logic [15:0] tag, output int acc_cyc);
        int   waited;
        logic done;
        waited     = 0;
        done       = 1'b0;
        acc_cyc    = -1;
        pkt_valid  = 1'b1;
        pkt_dst_ip = vecs[vi].ip;
        pkt_tag    = tag;
        while (!done) begin
            @(negedge clk);
            if (pkt_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(mk_exp(tag, vi));
            end else if (++waited > 200) begin
                done = 1'b1;
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: tag %0h never accepted", tag);
            end
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc0;
        int ready_seen;
        int resp_seen;
        int bad_seen;

        vecs[0] = '{32'h0a32b7fa, 1'b1, 16'h0003, 16'h0011, 48'h0011_2233_4455, 3'b001};
        vecs[1] = '{32'h0a32b708, 1'b1, 16'h0005, 16'h0022, 48'hffff_ffff_ffff, 3'b010};
        vecs[2] = '{32'h0a32b77d, 1'b1, 16'h0001, 16'h0033, 48'h00aa_bbcc_ddee, 3'b100};
        vecs[3] = '{32'h0a32b7dd, 1'b1, 16'h0007, 16'h0044, 48'h0200_dead_beef, 3'b000};
        vecs[4] = '{32'h0a32b7ff, 1'b0, 16'h0000, 16'h0000, 48'h0000_0000_0000, 3'b000};

        rst_n            = 1'b0;
        router_init_done = 1'b0;
        pkt_valid        = 1'b0;
        pkt_dst_ip       = '0;
        pkt_tag          = '0;
        fwd_ready        = 1'b1;
        inj_valid        = 1'b0;
        fork monitor(); join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_pkt_ready", pkt_ready, 0);
        check("rst_lookup", {lookup_valid, lookup_dst_ip}, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        check("rst_fwd_fields", {fwd_tag, fwd_found, fwd_out_port, fwd_out_qp, fwd_next_hop_mac, fwd_flags}, 0);
        check("rst_counters", {cnt_issued, cnt_miss, err_unexpected_resp}, 0);

        // Router table not loaded: no accepts even after the quiet window
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("init_gate", pkt_ready, 0);
        router_init_done = 1'b1;
        #1;
        check("init_ready", pkt_ready, 1);

        // Hit
        send(0, 16'h0001, acc);
        check("hit_lookup_valid", lookup_valid, 1);
        check("hit_lookup_ip", lookup_dst_ip, 32'h0a32b7fa);
        @(posedge clk);
        #1;
        check("hit_lookup_one_cycle", lookup_valid, 0);
        pop_cyc.delete();
        drain("hit_drain");
        check("hit_latency", (pop_cyc.size() > 0) ? pop_cyc[0] - acc : -1, 5);
        check("hit_cnt_issued", cnt_issued, 1);

        // Back-to-back
        pop_cyc.delete();
        acc0 = -1;
        for (int i = 0; i < 16; i++) begin
            send(i % 4, 16'(i), acc);
            if (i == 0) acc0 = acc;
        end
        drain("b2b_drain");
        check("b2b_first_latency", (pop_cyc.size() == 16) ? pop_cyc[0] - acc0 : -1, 5);
        check("b2b_consecutive", (pop_cyc.size() == 16) ? pop_cyc[15] - pop_cyc[0] : -1, 15);
        check("b2b_cnt_issued", cnt_issued, 17);

        // Backpressure
        fwd_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(i % 4, 16'h0200 + 16'(i), acc);
        check("bp_ready_low_after_8", pkt_ready, 0);
        pkt_valid  = 1'b1;
        pkt_dst_ip = vecs[0].ip;
        pkt_tag    = 16'h0208;
        ready_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (pkt_ready) ready_seen++;
        end
        check("bp_held_no_accept", ready_seen, 0);
        check("bp_head", {fwd_valid, fwd_tag}, {1'b1, 16'h0200});
        check("bp_cnt_issued", cnt_issued, 25);
        @(posedge clk);
        #1;
        fwd_ready = 1'b1;
        for (int i = 8; i < 12; i++) send(i % 4, 16'h0200 + 16'(i), acc);
        drain("bp_drain");
        check("bp_cnt_total", cnt_issued, 29);

        // Miss, then default route
        send(4, 16'h0300, acc);
        send(2, 16'h0301, acc);
        drain("miss_drain");
        check("miss_cnt_miss", cnt_miss, 1);
        check("miss_cnt_issued", cnt_issued, 31);
        check("miss_no_err", err_unexpected_resp, 0);

        // Reset with three lookups outstanding
        for (int i = 0; i < 3; i++) send(i, 16'h0400 + 16'(i), acc);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("mid_rst_outputs", {pkt_ready, lookup_valid, lookup_dst_ip, fwd_valid}, 0);
        check("mid_rst_counters", {cnt_issued, cnt_miss, err_unexpected_resp}, 0);
        rst_n     = 1'b1;
        resp_seen = 0;
        bad_seen  = 0;
        ready_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) resp_seen++;
            if (fwd_valid || err_unexpected_resp) bad_seen++;
            if (pkt_ready) ready_seen++;
        end
        check("quiet_ready_low", ready_seen, 0);
        check("quiet_silent_drop", bad_seen, 0);
        check("quiet_resps_landed", resp_seen > 0, 1);
        @(posedge clk);
        #1;
        check("quiet_end_ready", pkt_ready, 1);
        check("quiet_no_state", {fwd_valid, cnt_miss, err_unexpected_resp}, 0);

        // Spurious response with nothing outstanding
        inj_valid = 1'b1;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        check("spurious_err", err_unexpected_resp, 1);
        check("spurious_no_miss", cnt_miss, 0);
        repeat (4) @(posedge clk);
        #1;
        check("spurious_sticky", {err_unexpected_resp, fwd_valid}, {1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
